// File: rtl/i2c_target_model.sv
// Open-drain I2C target exposing a NumRegs-byte register file; bus edges act 3 clk_i cycles after the pins move.
// No backpressure: never stretches SCL; wr_valid_o is a 1-cycle strobe that cannot be stalled.
module i2c_target_model #(
  parameter logic [6:0]  Address = 7'h50,
  parameter int unsigned NumRegs = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       sda_oe_o,
  output logic                       wr_valid_o,
  output logic [$clog2(NumRegs)-1:0] wr_addr_o,
  output logic [7:0]                 wr_data_o,
  output logic                       busy_o
);

  localparam int unsigned AW = $clog2(NumRegs);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK
  } state_e;

  state_e          state_q, state_d;
  logic            scl_s1, scl_s2, scl_q, sda_s1, sda_s2, sda_q;
  logic            scl_rise, scl_fall, start_det, stop_det, byte_done;
  logic [7:0]      shift_q, byte_in;
  logic [2:0]      bit_cnt_q;
  logic            rw_q, first_q, sda_oe_d;
  logic [AW-1:0]   ptr_q;
  logic [7:0]      regs [NumRegs];

  // Idle bus is high on both lines, so the synchronizers reset to 1 to avoid a false START.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      {scl_s1, scl_s2, scl_q, sda_s1, sda_s2, sda_q} <= '1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_q  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_q  <= sda_s2;
    end
  end

  assign scl_rise  = scl_s2 & ~scl_q;
  assign scl_fall  = ~scl_s2 & scl_q;
  assign start_det = scl_s2 & scl_q & sda_q & ~sda_s2;
  assign stop_det  = scl_s2 & scl_q & ~sda_q & sda_s2;
  assign byte_in   = {shift_q[6:0], sda_s2};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = S_IDLE;
    end else if (start_det) begin
      state_d = S_ADDR;
    end else begin
      case (state_q)
        S_ADDR:     if (byte_done) state_d = (byte_in[7:1] == Address) ? S_ADDR_ACK : S_IDLE;
        S_ADDR_ACK: if (scl_rise)  state_d = rw_q ? S_RD_DATA : S_WR_DATA;
        S_WR_DATA:  if (byte_done) state_d = S_WR_ACK;
        S_WR_ACK:   if (scl_rise)  state_d = S_WR_DATA;
        S_RD_DATA:  if (byte_done) state_d = S_RD_ACK;
        S_RD_ACK:   if (scl_rise)  state_d = sda_s2 ? S_IDLE : S_RD_DATA;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  // SDA only moves after a detected SCL fall; START/STOP release wins over any drive.
  always_comb begin
    sda_oe_d = sda_oe_o;
    busy_o   = (state_q != S_IDLE);
    if (start_det || stop_det) begin
      sda_oe_d = 1'b0;
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR_ACK, S_WR_ACK: sda_oe_d = 1'b1;
        S_RD_DATA:            sda_oe_d = ~shift_q[7];
        default:              sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rw_q       <= 1'b0;
      first_q    <= 1'b0;
      ptr_q      <= '0;
      regs       <= '{default: '0};
      wr_valid_o <= 1'b0;
      wr_addr_o  <= '0;
      wr_data_o  <= '0;
      sda_oe_o   <= 1'b0;
    end else begin
      wr_valid_o <= 1'b0;
      sda_oe_o   <= sda_oe_d;
      if (start_det || stop_det) begin
        bit_cnt_q <= '0;
      end else if (scl_rise) begin
        case (state_q)
          S_ADDR: begin
            shift_q   <= byte_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_done) rw_q <= byte_in[0];
          end
          S_ADDR_ACK: begin
            first_q   <= 1'b1;
            bit_cnt_q <= '0;
            if (rw_q) shift_q <= regs[ptr_q];
          end
          S_WR_DATA: begin
            shift_q   <= byte_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            // The first byte after the address is the pointer, not data.
            if (byte_done) begin
              if (first_q) begin
                ptr_q   <= byte_in[AW-1:0];
                first_q <= 1'b0;
              end else begin
                regs[ptr_q] <= byte_in;
                wr_valid_o  <= 1'b1;
                wr_addr_o   <= ptr_q;
                wr_data_o   <= byte_in;
                ptr_q       <= ptr_q + AW'(1);
              end
            end
          end
          S_RD_DATA: begin
            shift_q   <= byte_in;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_done) ptr_q <= ptr_q + AW'(1);
          end
          S_RD_ACK: begin
            if (!sda_s2) begin
              shift_q   <= regs[ptr_q];
              bit_cnt_q <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_model.sv
// Bench for i2c_target_model: bit-banged host, queue-based register model, directed and random transfers.
module tb_i2c_target_model;

  localparam logic [6:0] ADDR  = 7'h50;
  localparam int         NREGS = 16;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       host_scl = 1'b1;
  logic       host_sda = 1'b1;
  logic       sda_oe_o, wr_valid_o, busy_o;
  logic [3:0] wr_addr_o;
  logic [7:0] wr_data_o;
  wire        sda_line = host_sda & ~sda_oe_o;

  always #5 clk_i = ~clk_i;

  i2c_target_model #(.Address(ADDR), .NumRegs(NREGS)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .scl_i      (host_scl),
    .sda_i      (sda_line),
    .sda_oe_o   (sda_oe_o),
    .wr_valid_o (wr_valid_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .busy_o     (busy_o)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  ref_regs [NREGS];
  logic [3:0]  ref_ptr;
  logic [11:0] exp_wr [$];
  logic [11:0] got_wr [$];
  int          oe_count = 0;

  // Monitor only appends; scenarios remember the log length before they start.
  always @(negedge clk_i) begin
    if (rst_ni && wr_valid_o) got_wr.push_back({wr_addr_o, wr_data_o});
    if (sda_oe_o) oe_count++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void m_reset();
    for (int i = 0; i < NREGS; i++) ref_regs[i] = 8'h00;
    ref_ptr = 4'd0;
  endfunction

  function automatic void m_ptr(input logic [7:0] b);
    ref_ptr = 4'(b % NREGS);
  endfunction

  function automatic void m_store(input logic [7:0] b);
    ref_regs[ref_ptr] = b;
    exp_wr.push_back({ref_ptr, b});
    ref_ptr = 4'((ref_ptr + 1) % NREGS);
  endfunction

  function automatic logic [7:0] m_read();
    logic [7:0] v;
    v = ref_regs[ref_ptr];
    ref_ptr = 4'((ref_ptr + 1) % NREGS);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic i2c_start();
    host_sda = 1'b1; tick(6);
    host_scl = 1'b1; tick(8);
    host_sda = 1'b0; tick(8);
    host_scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(6); host_sda = 1'b0;
    tick(6); host_scl = 1'b1;
    tick(8); host_sda = 1'b1;
    tick(8);
  endtask

  task automatic send_bit(input logic b, output logic s);
    tick(5); host_sda = b;
    tick(5); host_scl = 1'b1;
    tick(5); s = sda_line;
    tick(5); host_scl = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  task automatic read_byte(input bit host_ack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, s);
      d = {d[6:0], s};
    end
    send_bit(host_ack ? 1'b0 : 1'b1, s);
  endtask

  task automatic test_reset();
    tick(4);
    vectors++; if (sda_oe_o !== 1'b0)   begin miscompares++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe_o); end
    vectors++; if (wr_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_wr_valid: got %b want 0", wr_valid_o); end
    vectors++; if (wr_addr_o !== 4'd0)  begin miscompares++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr_o); end
    vectors++; if (wr_data_o !== 8'h00) begin miscompares++; $display("FAIL reset_wr_data: got %h want 00", wr_data_o); end
    vectors++; if (busy_o !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    rst_ni = 1'b1;
    m_reset();
    tick(5);
  endtask

  task automatic test_write_ptr();
    logic [7:0] bytes [4] = '{8'hA0, 8'h03, 8'h11, 8'h22};
    logic       ack;
    int         base = got_wr.size();
    i2c_start();
    tick(4);
    vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL wp_busy_start: got %b want 1", busy_o); end
    for (int i = 0; i < 4; i++) begin
      write_byte(bytes[i], ack);
      vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL wp_ack%0d: got %b want 0", i, ack); end
    end
    m_ptr(8'h03); m_store(8'h11); m_store(8'h22);
    i2c_stop();
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL wp_busy_stop: got %b want 0", busy_o); end
    vectors++;
    if (got_wr.size() - base !== 2) begin
      miscompares++; $display("FAIL wp_count: got %0d want 2", got_wr.size() - base);
    end else begin
      if (got_wr[base] !== 12'h311)   begin miscompares++; $display("FAIL wp_first: got %h want 311", got_wr[base]); end
      vectors++;
      if (got_wr[base+1] !== 12'h422) begin miscompares++; $display("FAIL wp_second: got %h want 422", got_wr[base+1]); end
    end
  endtask

  task automatic test_read_sr();
    logic       ack;
    logic [7:0] d;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h03, ack);
    m_ptr(8'h03);
    i2c_start();
    write_byte(8'hA1, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rd_addr_ack: got %b want 0", ack); end
    read_byte(1'b1, d);
    vectors++; if (d !== 8'h11) begin miscompares++; $display("FAIL rd_byte0: got %h want 11", d); end
    read_byte(1'b0, d);
    vectors++; if (d !== 8'h22) begin miscompares++; $display("FAIL rd_byte1: got %h want 22", d); end
    void'(m_read()); void'(m_read());
    tick(6);
    vectors++; if (sda_oe_o !== 1'b0) begin miscompares++; $display("FAIL rd_nack_release: got %b want 0", sda_oe_o); end
    vectors++; if (busy_o !== 1'b0)   begin miscompares++; $display("FAIL rd_nack_idle: got %b want 0", busy_o); end
    i2c_stop();
  endtask

  task automatic test_mismatch();
    logic ack;
    int   base = got_wr.size();
    int   oe0  = oe_count;
    i2c_start();
    write_byte(8'hB0, ack);
    vectors++; if (ack !== 1'b1)    begin miscompares++; $display("FAIL mm_addr_nack: got %b want 1", ack); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL mm_busy: got %b want 0", busy_o); end
    write_byte(8'h55, ack);
    vectors++; if (ack !== 1'b1)    begin miscompares++; $display("FAIL mm_data_nack: got %b want 1", ack); end
    i2c_stop();
    vectors++; if (oe_count !== oe0) begin miscompares++; $display("FAIL mm_sda_driven: got %0d cycles want 0", oe_count - oe0); end
    vectors++; if (got_wr.size() !== base) begin miscompares++; $display("FAIL mm_write: got %0d pulses want 0", got_wr.size() - base); end
  endtask

  task automatic test_wrap();
    logic       ack;
    logic [7:0] d;
    int         base = got_wr.size();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h0F, ack);
    write_byte(8'hAA, ack);
    write_byte(8'hBB, ack);
    i2c_stop();
    m_ptr(8'h0F); m_store(8'hAA); m_store(8'hBB);
    vectors++;
    if (got_wr.size() - base !== 2) begin
      miscompares++; $display("FAIL wrap_count: got %0d want 2", got_wr.size() - base);
    end else begin
      if (got_wr[base] !== 12'hFAA)   begin miscompares++; $display("FAIL wrap_first: got %h want FAA", got_wr[base]); end
      vectors++;
      if (got_wr[base+1] !== 12'h0BB) begin miscompares++; $display("FAIL wrap_second: got %h want 0BB", got_wr[base+1]); end
    end
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h1F, ack);
    m_ptr(8'h1F);
    i2c_start();
    write_byte(8'hA1, ack);
    read_byte(1'b1, d);
    vectors++; if (d !== 8'hAA) begin miscompares++; $display("FAIL wrap_rd15: got %h want AA", d); end
    read_byte(1'b0, d);
    vectors++; if (d !== 8'hBB) begin miscompares++; $display("FAIL wrap_rd0: got %h want BB", d); end
    void'(m_read()); void'(m_read());
    i2c_stop();
  endtask

  task automatic test_abort();
    logic       ack, s;
    logic [7:0] d, e;
    int         base = got_wr.size();
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h05, ack);
    m_ptr(8'h05);
    for (int i = 0; i < 4; i++) send_bit(1'b1, s);
    i2c_stop();
    vectors++; if (busy_o !== 1'b0)        begin miscompares++; $display("FAIL ab_idle: got %b want 0", busy_o); end
    vectors++; if (got_wr.size() !== base) begin miscompares++; $display("FAIL ab_write: got %0d pulses want 0", got_wr.size() - base); end
    i2c_start();
    write_byte(8'hA1, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL ab_next_ack: got %b want 0", ack); end
    read_byte(1'b0, d);
    e = m_read();
    vectors++; if (d !== e) begin miscompares++; $display("FAIL ab_reg5: got %h want %h", d, e); end
    i2c_stop();
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      logic [6:0] a;
      logic [7:0] b, d, e;
      logic       ack, match;
      int         n, base;
      a     = ($urandom_range(0, 1) == 1) ? ADDR : 7'($urandom_range(0, 127));
      match = (a == ADDR);
      exp_wr.delete();
      base  = got_wr.size();
      if ($urandom_range(0, 1) == 0) begin
        n = $urandom_range(1, 4);
        i2c_start();
        write_byte({a, 1'b0}, ack);
        vectors++; if (ack !== !match) begin miscompares++; $display("FAIL rnd%0d_waddr_ack: got %b want %b", it, ack, !match); end
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom_range(0, 255));
          write_byte(b, ack);
          if (match) begin
            if (k == 0) m_ptr(b);
            else        m_store(b);
          end
          vectors++; if (ack !== !match) begin miscompares++; $display("FAIL rnd%0d_wdata_ack: got %b want %b", it, ack, !match); end
        end
        i2c_stop();
        vectors++;
        if (got_wr.size() - base !== exp_wr.size()) begin
          miscompares++; $display("FAIL rnd%0d_wcount: got %0d want %0d", it, got_wr.size() - base, exp_wr.size());
        end else begin
          for (int k = 0; k < exp_wr.size(); k++) begin
            vectors++;
            if (got_wr[base+k] !== exp_wr[k]) begin miscompares++; $display("FAIL rnd%0d_wr%0d: got %h want %h", it, k, got_wr[base+k], exp_wr[k]); end
          end
        end
      end else begin
        i2c_start();
        if ($urandom_range(0, 1) == 1) begin
          b = 8'($urandom_range(0, 255));
          write_byte({ADDR, 1'b0}, ack);
          write_byte(b, ack);
          m_ptr(b);
          i2c_start();
        end
        write_byte({a, 1'b1}, ack);
        vectors++; if (ack !== !match) begin miscompares++; $display("FAIL rnd%0d_raddr_ack: got %b want %b", it, ack, !match); end
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          read_byte(k < n - 1, d);
          e = match ? m_read() : 8'hFF;
          vectors++; if (d !== e) begin miscompares++; $display("FAIL rnd%0d_rd%0d: got %h want %h", it, k, d, e); end
        end
        i2c_stop();
      end
      vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rnd%0d_busy: got %b want 0", it, busy_o); end
    end
  endtask

  task automatic test_reset_mid_read();
    logic       ack;
    logic [7:0] d, e;
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h07, ack);
    write_byte(8'h0F, ack);
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h07, ack);
    i2c_start();
    write_byte(8'hA1, ack);
    tick(6);
    vectors++; if (sda_oe_o !== 1'b1) begin miscompares++; $display("FAIL rst_pre_drive: got %b want 1", sda_oe_o); end
    rst_ni = 1'b0;
    tick(1);
    vectors++; if (sda_oe_o !== 1'b0)   begin miscompares++; $display("FAIL rst_release: got %b want 0", sda_oe_o); end
    vectors++; if (busy_o !== 1'b0)     begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    vectors++; if (wr_addr_o !== 4'd0)  begin miscompares++; $display("FAIL rst_wr_addr: got %h want 0", wr_addr_o); end
    vectors++; if (wr_data_o !== 8'h00) begin miscompares++; $display("FAIL rst_wr_data: got %h want 00", wr_data_o); end
    host_scl = 1'b1; tick(4);
    host_sda = 1'b1; tick(4);
    rst_ni = 1'b1;
    m_reset();
    tick(6);
    i2c_start();
    write_byte(8'hA1, ack);
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL rst_addr_ack: got %b want 0", ack); end
    for (int k = 0; k < NREGS; k++) begin
      read_byte(k < NREGS - 1, d);
      e = m_read();
      vectors++; if (d !== e) begin miscompares++; $display("FAIL rst_reg%0d: got %h want %h", k, d, e); end
    end
    i2c_stop();
  endtask

  initial begin
    test_reset();
    test_write_ptr();
    test_read_sr();
    test_mismatch();
    test_wrap();
    test_abort();
    test_random();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
